// File: rtl/kitchen_timer_ctrl.sv
// Kitchen countdown timer: BCD mm:ss setup in IDLE, 1 Hz countdown in RUN,
// pause/resume, and a self-expiring alarm that any control button acknowledges.
module kitchen_timer_ctrl #(
  parameter int ALARM_SECS = 10
) (
  input  logic       in_clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       btn_min_inc,
  input  logic       btn_sec_inc,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       alarm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_ALARM = 2'b11
  } state_e;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } bcd_time_t;

  localparam logic [7:0] ALARM_LIM = 8'(ALARM_SECS);

  state_e     cur_q, nxt;
  bcd_time_t  tm_q, tm_d;
  logic [7:0] acnt_q, acnt_d;
  logic       tm_zero, tm_one;

  // Two-digit BCD increment; tens wrap back to 0 after tens_max with ones at 9,
  // so seconds wrap 59->00 and minutes 99->00 with no carry out.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [3:0] tens_max);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == tens_max) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // One-second decrement with borrow; saturates at 00:00 so digits stay legal.
  function automatic bcd_time_t tm_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t == '0) begin
      r = '0;
    end else if (t.so != 4'd0) begin
      r.so = t.so - 4'd1;
    end else if (t.st != 4'd0) begin
      r.st = t.st - 4'd1;
      r.so = 4'd9;
    end else begin
      r.st = 4'd5;
      r.so = 4'd9;
      if (t.mo != 4'd0) begin
        r.mo = t.mo - 4'd1;
      end else begin
        r.mo = 4'd9;
        r.mt = t.mt - 4'd1;
      end
    end
    return r;
  endfunction

  assign tm_zero = (tm_q == '0);
  assign tm_one  = (tm_q == 16'h0001);

  always_comb begin
    nxt    = cur_q;
    tm_d   = tm_q;
    acnt_d = acnt_q;
    case (cur_q)
      S_IDLE: begin
        if (btn_clear) begin
          tm_d = '0;
        end else if (btn_stop) begin
          tm_d = tm_q;
        end else if (btn_start) begin
          if (!tm_zero) nxt = S_RUN;
        end else begin
          if (btn_sec_inc) {tm_d.st, tm_d.so} = bcd2_inc({tm_q.st, tm_q.so}, 4'd5);
          if (btn_min_inc) {tm_d.mt, tm_d.mo} = bcd2_inc({tm_q.mt, tm_q.mo}, 4'd9);
        end
      end
      S_RUN: begin
        if (btn_clear) begin
          nxt  = S_IDLE;
          tm_d = '0;
        end else if (btn_stop) begin
          nxt = S_PAUSE;
        end else if (sec_tick) begin
          tm_d = tm_dec(tm_q);
          if (tm_one) nxt = S_ALARM;
        end
      end
      S_PAUSE: begin
        if (btn_clear) begin
          nxt  = S_IDLE;
          tm_d = '0;
        end else if (btn_stop) begin
          nxt = S_PAUSE;
        end else if (btn_start) begin
          nxt = S_RUN;
        end
      end
      S_ALARM: begin
        if (btn_clear || btn_stop || btn_start) begin
          nxt  = S_IDLE;
          tm_d = '0;
        end else if (sec_tick) begin
          acnt_d = acnt_q + 8'd1;
          if (acnt_q + 8'd1 == ALARM_LIM) nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
    // Fresh alarm duration on every entry.
    if (nxt == S_ALARM && cur_q != S_ALARM) acnt_d = '0;
  end

  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      cur_q  <= S_IDLE;
      tm_q   <= '0;
      acnt_q <= '0;
      alarm  <= 1'b0;
    end else begin
      cur_q  <= nxt;
      tm_q   <= tm_d;
      acnt_q <= acnt_d;
      alarm  <= (nxt == S_ALARM);
    end
  end

  assign state    = cur_q;
  assign min_tens = tm_q.mt;
  assign min_ones = tm_q.mo;
  assign sec_tens = tm_q.st;
  assign sec_ones = tm_q.so;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// Directed scenarios plus random traffic against a seconds-count reference model.
module tb_kitchen_timer_ctrl;
  localparam int ASECS = 3;

  logic       in_clk = 1'b0;
  logic       rst_n, sec_tick, btn_start, btn_stop, btn_clear, btn_min_inc, btn_sec_inc;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  // Reference model: minutes/seconds as integers, state as 0..3.
  int m_mm = 0, m_ss = 0, m_st = 0, m_acnt = 0;

  kitchen_timer_ctrl #(.ALARM_SECS(ASECS)) dut (
    .in_clk(in_clk), .rst_n(rst_n), .sec_tick(sec_tick),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear),
    .btn_min_inc(btn_min_inc), .btn_sec_inc(btn_sec_inc),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .state(state), .alarm(alarm)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_time();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] mdl_time();
    return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
  endfunction

  task automatic model_step(input bit r, input bit tk, input bit st, input bit sp,
                            input bit cl, input bit mi, input bit si);
    int t;
    if (!r) begin
      m_mm = 0; m_ss = 0; m_st = 0; m_acnt = 0;
      return;
    end
    case (m_st)
      0: begin
        if (cl) begin m_mm = 0; m_ss = 0; end
        else if (sp) ;
        else if (st) begin if (m_mm * 60 + m_ss != 0) m_st = 1; end
        else begin
          if (si) m_ss = (m_ss + 1) % 60;
          if (mi) m_mm = (m_mm + 1) % 100;
        end
      end
      1: begin
        if (cl) begin m_mm = 0; m_ss = 0; m_st = 0; end
        else if (sp) m_st = 2;
        else if (tk) begin
          t = m_mm * 60 + m_ss - 1;
          m_mm = t / 60; m_ss = t % 60;
          if (t == 0) begin m_st = 3; m_acnt = 0; end
        end
      end
      2: begin
        if (cl) begin m_mm = 0; m_ss = 0; m_st = 0; end
        else if (st && !sp) m_st = 1;
      end
      default: begin
        if (cl || sp || st) begin m_st = 0; m_mm = 0; m_ss = 0; end
        else if (tk) begin
          m_acnt++;
          if (m_acnt == ASECS) m_st = 0;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare #1 after the edge.
  task automatic cyc(input bit tk, input bit st = 0, input bit sp = 0, input bit cl = 0,
                     input bit mi = 0, input bit si = 0, input bit r = 1);
    rst_n = r; sec_tick = tk; btn_start = st; btn_stop = sp; btn_clear = cl;
    btn_min_inc = mi; btn_sec_inc = si;
    @(posedge in_clk);
    model_step(r, tk, st, sp, cl, mi, si);
    #1;
    chk("state", 16'(state), 16'(m_st));
    chk("time",  dut_time(), mdl_time());
    chk("alarm", 16'(alarm), 16'(m_st == 3));
  endtask

  initial begin
    cyc(1, 1, 1, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_time", dut_time(), 16'h0000);
    chk("rst_state", 16'(state), 16'd0);

    // Seconds wrap without carry, minutes wrap at 99.
    repeat (61) cyc(0, 0, 0, 0, 0, 1);
    chk("sec61", dut_time(), 16'h0001);
    repeat (100) cyc(0, 0, 0, 0, 1, 0);
    chk("min100", dut_time(), 16'h0001);
    cyc(0, 0, 0, 0, 1, 1);
    chk("both_inc", dut_time(), 16'h0102);

    // 01:00 countdown into alarm.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1);
    cyc(1);
    chk("run_0059", dut_time(), 16'h0059);
    chk("run_state", 16'(state), 16'd1);
    repeat (59) cyc(1);
    chk("alarm_on", {alarm, 13'd0, state}, {1'b1, 13'd0, 2'd3});
    chk("alarm_time", dut_time(), 16'h0000);

    // Alarm self-expires on the 3rd tick.
    cyc(1); cyc(0); cyc(1);
    chk("alarm_hold", 16'(state), 16'd3);
    cyc(1);
    chk("alarm_expire", {alarm, 13'd0, state}, 16'd0);

    // Alarm acknowledged with stop.
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1);
    cyc(1);
    chk("alarm2", 16'(state), 16'd3);
    cyc(0, 0, 1);
    chk("alarm_ack", {alarm, 13'd0, state}, 16'd0);

    // Stop with same-cycle tick discards the tick; pause ignores ticks.
    repeat (5) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1);
    cyc(1, 0, 1);
    chk("pause_0005", {dut_time(), 14'd0, state}, {16'h0005, 14'd0, 2'd2});
    repeat (3) cyc(1);
    chk("pause_hold", dut_time(), 16'h0005);
    cyc(0, 1);
    cyc(1);
    chk("resume_0004", dut_time(), 16'h0004);

    // Clear beats stop; start at 00:00 is ignored.
    cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1);
    cyc(0, 0, 1, 1);
    chk("clr_stop", {dut_time(), 14'd0, state}, 32'd0);
    cyc(0, 1);
    chk("start_zero", 16'(state), 16'd0);

    // Reset mid-run with a tick.
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    cyc(0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_run", {alarm, dut_time(), state}, 19'd0);
    cyc(1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(2) == 0,
          $urandom_range(9) == 0,
          $urandom_range(14) == 0,
          $urandom_range(49) == 0,
          $urandom_range(5) == 0,
          $urandom_range(3) == 0,
          $urandom_range(399) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
